// File: rtl/vga_timing_gen_pkg.sv
`timescale 1ns/1ps
// Shared 640x480@60 raster constants, sync polarity and range helper.
// Also used by text-overlay placement for the visible-area bounds.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam logic SYNC_ACTIVE = 1'b0;

  function automatic logic in_range(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
`timescale 1ns/1ps
// Raster timing bundle from the timing generator to glyph renderer / colour mux.
// Pure broadcast: no handshake, consumers sample on pixel_tick.
interface vga_timing_if;

  logic                             pixel_tick;
  logic [vga_timing_pkg::CNT_W-1:0] x;
  logic [vga_timing_pkg::CNT_W-1:0] y;
  logic                             hsync;
  logic                             vsync;
  logic                             video_on;
  logic                             line_start;
  logic                             frame_start;

  modport master (
    output pixel_tick, x, y, hsync, vsync, video_on, line_start, frame_start
  );

  modport slave (
    input pixel_tick, x, y, hsync, vsync, video_on, line_start, frame_start
  );

endinterface

// File: rtl/vga_timing_gen_pixel_tick_div.sv
`timescale 1ns/1ps
// Divides clk down to a one-clock pixel strobe every PIX_DIV clocks.
// Strobe is a decode of the counter; with PIX_DIV=1 the counter stays 0 and tick is always high.
module pixel_tick_div #(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [W-1:0] r_div_cnt;
  logic         w_last;

  generate
    if (PIX_DIV < 1) begin : g_bad_div
      $error("pixel_tick_div: PIX_DIV must be >= 1");
    end
  endgenerate

  assign w_last = (r_div_cnt == W'(PIX_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
    end else if (w_last) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + W'(1);
    end
  end

  assign tick = w_last;

endmodule

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// Raster x/y counters with registered sync/blank decode; zero latency relative to x/y.
// No backpressure: free-running, outputs change only on pixel_tick edges.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int PIX_DIV   = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  vga_timing_if.master vga
);

  localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int HS_LO = H_DISPLAY + H_FRONT;
  localparam int HS_HI = H_DISPLAY + H_FRONT + H_SYNC - 1;
  localparam int VS_LO = V_DISPLAY + V_FRONT;
  localparam int VS_HI = V_DISPLAY + V_FRONT + V_SYNC - 1;

  generate
    if ((H_TOT > (1 << CNT_W)) || (V_TOT > (1 << CNT_W))) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must each be <= 1024");
    end
  endgenerate

  logic             w_tick;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic [CNT_W-1:0] w_x_nxt;
  logic [CNT_W-1:0] w_y_nxt;
  logic             w_x_wrap;
  logic             w_y_wrap;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic             w_hsync_nxt;
  logic             w_vsync_nxt;
  logic             w_video_on_nxt;

  pixel_tick_div #(
    .PIX_DIV (PIX_DIV)
  ) u_pixel_tick_div (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  assign w_x_wrap = (r_x == CNT_W'(H_TOT - 1));
  assign w_y_wrap = (r_y == CNT_W'(V_TOT - 1));

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_tick) begin
      if (w_x_wrap) begin
        w_x_nxt = '0;
        w_y_nxt = w_y_wrap ? '0 : r_y + CNT_W'(1);
      end else begin
        w_x_nxt = r_x + CNT_W'(1);
      end
    end
  end

  // Decode from next-state counts so registered syncs flip on the same edge as x/y.
  always_comb begin
    w_hsync_nxt    = in_range(w_x_nxt, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    w_vsync_nxt    = in_range(w_y_nxt, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    w_video_on_nxt = (w_x_nxt < CNT_W'(H_DISPLAY)) && (w_y_nxt < CNT_W'(V_DISPLAY));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_hsync    <= ~SYNC_ACTIVE;
      r_vsync    <= ~SYNC_ACTIVE;
      r_video_on <= 1'b1;
    end else begin
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_hsync    <= w_hsync_nxt;
      r_vsync    <= w_vsync_nxt;
      r_video_on <= w_video_on_nxt;
    end
  end

  assign vga.pixel_tick  = w_tick;
  assign vga.x           = r_x;
  assign vga.y           = r_y;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.video_on    = r_video_on;
  assign vga.line_start  = w_tick && (r_x == '0);
  assign vga.frame_start = w_tick && (r_x == '0) && (r_y == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen: default timing, PIX_DIV=1, and a tiny raster for full-frame checks.
module tb_vga_timing_gen;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic rst_c;

  vga_timing_if if_a ();
  vga_timing_if if_b ();
  vga_timing_if if_c ();

  vga_timing_gen u_dut_a (
    .clk     (clk),
    .reset_n (rst_a),
    .vga     (if_a)
  );

  vga_timing_gen #(
    .PIX_DIV (1)
  ) u_dut_b (
    .clk     (clk),
    .reset_n (rst_b),
    .vga     (if_b)
  );

  // Tiny raster: H 8+2+3+2=15, V 6+2+2+3=13, PIX_DIV 2 -> 390 clocks per frame.
  vga_timing_gen #(
    .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_DISPLAY (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .PIX_DIV   (2)
  ) u_dut_c (
    .clk     (clk),
    .reset_n (rst_c),
    .vga     (if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int c      = 0;

  typedef struct {
    int   cyc;
    logic tick;
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic vo;
    logic ls;
    logic fs;
  } vec_t;

  vec_t vec[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Walks instance A from clock c (0 = clock right after reset release) through the first n vectors.
  task automatic run_vec(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      while (c < vec[i].cyc) begin
        @(negedge clk);
        c++;
      end
      chk($sformatf("%s[%0d].tick", tag, i), 32'(if_a.pixel_tick),  32'(vec[i].tick));
      chk($sformatf("%s[%0d].x",    tag, i), 32'(if_a.x),           vec[i].x);
      chk($sformatf("%s[%0d].y",    tag, i), 32'(if_a.y),           vec[i].y);
      chk($sformatf("%s[%0d].hs",   tag, i), 32'(if_a.hsync),       32'(vec[i].hs));
      chk($sformatf("%s[%0d].vs",   tag, i), 32'(if_a.vsync),       32'(vec[i].vs));
      chk($sformatf("%s[%0d].vo",   tag, i), 32'(if_a.video_on),    32'(vec[i].vo));
      chk($sformatf("%s[%0d].ls",   tag, i), 32'(if_a.line_start),  32'(vec[i].ls));
      chk($sformatf("%s[%0d].fs",   tag, i), 32'(if_a.frame_start), 32'(vec[i].fs));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   mx;
    int   my;
    int   last_fs;
    int   n_fs;
    logic exp_tick;

    //          cyc   tk  x    y  hs vs vo ls fs
    vec[0]  = '{0,    0,  0,   0, 1, 1, 1, 0, 0};
    vec[1]  = '{2,    0,  0,   0, 1, 1, 1, 0, 0};
    vec[2]  = '{3,    1,  0,   0, 1, 1, 1, 1, 1};
    vec[3]  = '{4,    0,  1,   0, 1, 1, 1, 0, 0};
    vec[4]  = '{7,    1,  1,   0, 1, 1, 1, 0, 0};
    vec[5]  = '{11,   1,  2,   0, 1, 1, 1, 0, 0};
    vec[6]  = '{2559, 1,  639, 0, 1, 1, 1, 0, 0};
    vec[7]  = '{2560, 0,  640, 0, 1, 1, 0, 0, 0};
    vec[8]  = '{2623, 1,  655, 0, 1, 1, 0, 0, 0};
    vec[9]  = '{2624, 0,  656, 0, 0, 1, 0, 0, 0};
    vec[10] = '{3007, 1,  751, 0, 0, 1, 0, 0, 0};
    vec[11] = '{3008, 0,  752, 0, 1, 1, 0, 0, 0};
    vec[12] = '{3199, 1,  799, 0, 1, 1, 0, 0, 0};
    vec[13] = '{3200, 0,  0,   1, 1, 1, 1, 0, 0};
    vec[14] = '{3203, 1,  0,   1, 1, 1, 1, 1, 0};

    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_a.tick", 32'(if_a.pixel_tick), 0);
    chk("rst_a.x",    32'(if_a.x),          0);
    chk("rst_a.y",    32'(if_a.y),          0);
    chk("rst_a.hs",   32'(if_a.hsync),      1);
    chk("rst_a.vs",   32'(if_a.vsync),      1);
    chk("rst_a.vo",   32'(if_a.video_on),   1);
    chk("rst_b.tick", 32'(if_b.pixel_tick), 1);
    chk("rst_b.x",    32'(if_b.x),          0);

    // Default timing: reset release and one full line plus the next line start.
    rst_a = 1'b1;
    c = 0;
    run_vec(15, "A");

    // Reset mid-line at x=700, y=1 while hsync is active.
    while (c < 6000) begin
      @(negedge clk);
      c++;
    end
    chk("pre_rst.x",  32'(if_a.x),     700);
    chk("pre_rst.y",  32'(if_a.y),     1);
    chk("pre_rst.hs", 32'(if_a.hsync), 0);
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    #1;
    chk("async_rst.x",    32'(if_a.x),          0);
    chk("async_rst.y",    32'(if_a.y),          0);
    chk("async_rst.hs",   32'(if_a.hsync),      1);
    chk("async_rst.vs",   32'(if_a.vsync),      1);
    chk("async_rst.vo",   32'(if_a.video_on),   1);
    chk("async_rst.tick", 32'(if_a.pixel_tick), 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    c = 0;
    run_vec(6, "A2");

    // PIX_DIV=1: tick always high, x advances every clock, 800-clock lines.
    rst_b = 1'b1;
    for (int k = 0; k <= 1600; k++) begin
      chk("B.tick", 32'(if_b.pixel_tick), 1);
      chk("B.x",    32'(if_b.x),          k % 800);
      chk("B.y",    32'(if_b.y),          k / 800);
      chk("B.ls",   32'(if_b.line_start), 32'((k % 800) == 0));
      @(negedge clk);
    end

    // Tiny raster: two full frames against an independent raster model.
    rst_c   = 1'b1;
    mx      = 0;
    my      = 0;
    last_fs = -1;
    n_fs    = 0;
    for (int k = 0; k < 800; k++) begin
      exp_tick = (k % 2) == 1;
      chk("C.tick", 32'(if_c.pixel_tick), 32'(exp_tick));
      chk("C.x",    32'(if_c.x),          mx);
      chk("C.y",    32'(if_c.y),          my);
      chk("C.vo",   32'(if_c.video_on),   32'((mx < 8) && (my < 6)));
      chk("C.hs",   32'(if_c.hsync),      32'(!((mx >= 10) && (mx <= 12))));
      chk("C.vs",   32'(if_c.vsync),      32'(!((my >= 8) && (my <= 9))));
      chk("C.vo_coh", 32'(if_c.video_on), 32'((if_c.x < 8) && (if_c.y < 6)));
      chk("C.ls",   32'(if_c.line_start),  32'(exp_tick && (mx == 0)));
      chk("C.fs",   32'(if_c.frame_start), 32'(exp_tick && (mx == 0) && (my == 0)));
      if (if_c.frame_start === 1'b1) begin
        if (last_fs >= 0) chk("C.frame_period", k - last_fs, 390);
        last_fs = k;
        n_fs++;
      end
      if (exp_tick) begin
        if (mx == 14) begin
          mx = 0;
          my = (my == 12) ? 0 : my + 1;
        end else begin
          mx = mx + 1;
        end
      end
      @(negedge clk);
    end
    chk("C.frame_count", n_fs, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
